// File: rtl/pool_window_gen.sv
// pool_window_gen: groups a raster-order 4-bit pixel stream into
// non-overlapping 2x2 windows using a single line buffer, and emits each
// window as four 15-bit thermometer codes with a one-cycle valid pulse.
module pool_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pix_in,
    input  logic        pix_valid,
    output logic [14:0] win_in1,
    output logic [14:0] win_in2,
    output logic [14:0] win_in3,
    output logic [14:0] win_in4,
    output logic        win_valid,
    output logic        frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Thermometer code: value v sets bits [v-1:0].
    function automatic logic [14:0] therm(input logic [3:0] v);
        logic [14:0] code;
        code = 15'd0;
        for (int i = 0; i < 15; i++) begin
            code[i] = (v > 4'(i));
        end
        return code;
    endfunction

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;
    logic [3:0]    linebuf_r [IMG_W];
    logic [3:0]    held_bl_r;
    logic [14:0]   win1_r;
    logic [14:0]   win2_r;
    logic [14:0]   win3_r;
    logic [14:0]   win4_r;
    logic          win_valid_r;
    logic          frame_done_r;

    logic          last_col_s;
    logic          last_row_s;
    logic          win_fire_s;
    logic          lb_write_s;
    logic          hold_capture_s;
    logic [CW-1:0] left_col_s;

    assign last_col_s     = (col_r == COL_LAST);
    assign last_row_s     = (row_r == ROW_LAST);
    // Odd row + odd column is the bottom-right pixel of a window.
    assign win_fire_s     = pix_valid & row_r[0] & col_r[0];
    assign lb_write_s     = pix_valid & ~row_r[0];
    assign hold_capture_s = pix_valid & row_r[0] & ~col_r[0];
    assign left_col_s     = col_r - CW'(1);

    // Next raster position: advance only on accepted pixels, wrapping per line and per frame.
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (pix_valid) begin
            if (last_col_s) begin
                col_nxt_s = {CW{1'b0}};
                if (last_row_s) begin
                    row_nxt_s = {RW{1'b0}};
                end else begin
                    row_nxt_s = row_r + RW'(1);
                end
            end else begin
                col_nxt_s = col_r + CW'(1);
                row_nxt_s = row_r;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // Position counters and bottom-left holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r     <= {CW{1'b0}};
            row_r     <= {RW{1'b0}};
            held_bl_r <= 4'd0;
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
            if (hold_capture_s) begin
                held_bl_r <= pix_in;
            end
        end
    end

    // Line buffer of the top row of the current row pair; always written before read, so no reset.
    always_ff @(posedge clk) begin
        if (lb_write_s) begin
            linebuf_r[col_r] <= pix_in;
        end
    end

    // Registered window outputs and single-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win1_r       <= 15'd0;
            win2_r       <= 15'd0;
            win3_r       <= 15'd0;
            win4_r       <= 15'd0;
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            win_valid_r  <= win_fire_s;
            frame_done_r <= win_fire_s & last_col_s & last_row_s;
            if (win_fire_s) begin
                win1_r <= therm(linebuf_r[left_col_s]);
                win2_r <= therm(linebuf_r[col_r]);
                win3_r <= therm(held_bl_r);
                win4_r <= therm(pix_in);
            end
        end
    end

    assign win_in1    = win1_r;
    assign win_in2    = win2_r;
    assign win_in3    = win3_r;
    assign win_in4    = win4_r;
    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: a 4x2 instance for the basic, encoding,
// gapped and reset scenarios, and a 4x4 instance for back-to-back frames.
module tb_pool_window_gen;

    logic        clk;
    logic        rst;
    logic [3:0]  pix_a;
    logic        valid_a;
    logic [14:0] a1, a2, a3, a4;
    logic        wv_a, fd_a;
    logic [3:0]  pix_b;
    logic        valid_b;
    logic [14:0] b1, b2, b3, b4;
    logic        wv_b, fd_b;

    int n_checks = 0;
    int n_fail   = 0;

    pool_window_gen #(.IMG_W(4), .IMG_H(2)) dut_a (
        .clk(clk), .rst(rst), .pix_in(pix_a), .pix_valid(valid_a),
        .win_in1(a1), .win_in2(a2), .win_in3(a3), .win_in4(a4),
        .win_valid(wv_a), .frame_done(fd_a)
    );

    pool_window_gen #(.IMG_W(4), .IMG_H(4)) dut_b (
        .clk(clk), .rst(rst), .pix_in(pix_b), .pix_valid(valid_b),
        .win_in1(b1), .win_in2(b2), .win_in3(b3), .win_in4(b4),
        .win_valid(wv_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference thermometer code, independent formulation.
    function automatic logic [14:0] tcode(input int v);
        logic [15:0] t;
        t = (16'd1 << v) - 16'd1;
        return t[14:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_win_a(input string tag, input int p1, input int p2, input int p3, input int p4);
        chk({tag, "_w1"}, a1, tcode(p1));
        chk({tag, "_w2"}, a2, tcode(p2));
        chk({tag, "_w3"}, a3, tcode(p3));
        chk({tag, "_w4"}, a4, tcode(p4));
    endtask

    // Accept one pixel on dut_a, then check the pulses one cycle later.
    task automatic send_a(input int v, input logic exp_wv, input logic exp_fd, input string tag);
        @(negedge clk);
        pix_a   = 4'(v);
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_wv"}, wv_a, exp_wv);
        chk({tag, "_fd"}, fd_a, exp_fd);
    endtask

    task automatic idle_a(input string tag);
        @(negedge clk);
        valid_a = 1'b0;
        pix_a   = 4'hA;
        @(posedge clk);
        #1;
        chk({tag, "_idle_wv"}, wv_a, 1'b0);
        chk({tag, "_idle_fd"}, fd_a, 1'b0);
    endtask

    task automatic basic_frame_a(input string tag, input int gap);
        for (int i = 1; i <= 8; i++) begin
            send_a(i, (i == 6) || (i == 8), (i == 8), tag);
            if (i == 6) chk_win_a({tag, "_win0"}, 1, 2, 5, 6);
            if (i == 7) chk_win_a({tag, "_hold"}, 1, 2, 5, 6);
            if (i == 8) chk_win_a({tag, "_win1"}, 3, 4, 7, 8);
            for (int g = 0; g < gap; g++) idle_a(tag);
        end
    endtask

    initial begin
        int pv, tl, tr, bl, br, wcount, fdcount;
        rst     = 1'b1;
        pix_a   = 4'd0;
        valid_a = 1'b0;
        pix_b   = 4'd0;
        valid_b = 1'b0;
        #1;
        chk("rst_w1", a1, 15'd0);
        chk("rst_w4", a4, 15'd0);
        chk("rst_wv", wv_a, 1'b0);
        chk("rst_fd", fd_a, 1'b0);
        chk("rst_b_wv", wv_b, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic 4x2 frame with continuous valid.
        basic_frame_a("basic", 0);

        // Encoding extremes: window 0,15 / 15,0 then an all-zero window.
        send_a(0,  1'b0, 1'b0, "enc");
        send_a(15, 1'b0, 1'b0, "enc");
        send_a(0,  1'b0, 1'b0, "enc");
        send_a(0,  1'b0, 1'b0, "enc");
        send_a(15, 1'b0, 1'b0, "enc");
        send_a(0,  1'b1, 1'b0, "enc");
        chk("enc_w1", a1, 15'h0000);
        chk("enc_w2", a2, 15'h7FFF);
        chk("enc_w3", a3, 15'h7FFF);
        chk("enc_w4", a4, 15'h0000);
        send_a(0,  1'b0, 1'b0, "enc");
        send_a(0,  1'b1, 1'b1, "enc");
        chk_win_a("enc_zero", 0, 0, 0, 0);

        // Same frame with 3 idle cycles after every pixel.
        basic_frame_a("gap", 3);
        idle_a("gap_tail");

        // Reset after 5 pixels of a frame.
        for (int i = 1; i <= 5; i++) send_a(i, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        valid_a = 1'b0;
        rst     = 1'b1;
        #1;
        chk("mrst_w1", a1, 15'd0);
        chk("mrst_w2", a2, 15'd0);
        chk("mrst_w3", a3, 15'd0);
        chk("mrst_w4", a4, 15'd0);
        chk("mrst_wv", wv_a, 1'b0);
        chk("mrst_fd", fd_a, 1'b0);
        @(posedge clk);
        #1;
        chk("mrst_hold_wv", wv_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        basic_frame_a("post_rst", 0);

        // Two contiguous 4x4 frames on dut_b.
        wcount  = 0;
        fdcount = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    pv = (f == 0) ? (r * 4 + c) : (15 - (r * 4 + c));
                    @(negedge clk);
                    pix_b   = 4'(pv);
                    valid_b = 1'b1;
                    @(posedge clk);
                    #1;
                    if ((r % 2 == 1) && (c % 2 == 1)) begin
                        wcount++;
                        tl = (f == 0) ? ((r - 1) * 4 + c - 1) : (15 - ((r - 1) * 4 + c - 1));
                        tr = (f == 0) ? ((r - 1) * 4 + c)     : (15 - ((r - 1) * 4 + c));
                        bl = (f == 0) ? (r * 4 + c - 1)       : (15 - (r * 4 + c - 1));
                        br = pv;
                        chk("b2b_wv", wv_b, 1'b1);
                        chk("b2b_fd", fd_b, ((wcount == 4) || (wcount == 8)) ? 1'b1 : 1'b0);
                        chk("b2b_w1", b1, tcode(tl));
                        chk("b2b_w2", b2, tcode(tr));
                        chk("b2b_w3", b3, tcode(bl));
                        chk("b2b_w4", b4, tcode(br));
                        if (fd_b === 1'b1) fdcount++;
                    end else begin
                        chk("b2b_nowv", wv_b, 1'b0);
                        chk("b2b_nofd", fd_b, 1'b0);
                    end
                end
            end
        end
        @(negedge clk);
        valid_b = 1'b0;
        chk("b2b_fd_count", 32'(fdcount), 32'd2);
        @(posedge clk);
        #1;
        chk("b2b_tail_wv", wv_b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_window_gen.md
# pool_window_gen

Upstream feeder for the 2x2 pooling filter. It accepts a raster-order stream of 4-bit pixels, buffers one image line, and groups the pixels into non-overlapping 2x2 windows. It emits each window as four 15-bit thermometer codes on the same cycle, ready for the thermometer-majority pooling stage.

## Interface
- IMG_W, default 8: image width in pixels; must be even and at least 2.
- IMG_H, default 8: image height in lines; must be even and at least 2.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pix_in  input  4  pixel value, 0..15.
- pix_valid  input  1  pix_in is accepted on any rising edge where this is high. There is no backpressure.
- win_in1  output  15  thermometer code of the window's top-left pixel.
- win_in2  output  15  thermometer code of the window's top-right pixel.
- win_in3  output  15  thermometer code of the window's bottom-left pixel.
- win_in4  output  15  thermometer code of the window's bottom-right pixel.
- win_valid  output  1  one-cycle pulse: win_in1..4 hold a complete window.
- frame_done  output  1  one-cycle pulse, coincident with win_valid of the last window of a frame.

## Operation
- Thermometer encoding: a value v maps to a code with bits [v-1:0] set and all higher bits clear.
  - 0 -> 15'b000000000000000.
  - 3 -> 15'b000000000000111.
  - 15 -> 15'b111111111111111.
- Position counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1.
  - Both advance only on accepted pixels.
  - col wraps to 0 and increments row at the end of a line.
  - row wraps to 0 after the last line, so the next frame starts immediately.
- Even rows (row[0]=0): each pixel is written to the line buffer at index col. The line buffer holds IMG_W entries of 4 bits.
- Odd rows, even col: the pixel is captured into a bottom-left holding register.
- Odd rows, odd col (window completes):
  - win_in1 = therm(linebuf[col-1]).
  - win_in2 = therm(linebuf[col]).
  - win_in3 = therm(held bottom-left).
  - win_in4 = therm(pix_in).
  - All four are registered and win_valid is asserted.
- Window order: left to right within a row pair, then top to bottom. That gives (IMG_W/2)*(IMG_H/2) windows per frame.
- frame_done is asserted with the window completed at row=IMG_H-1, col=IMG_W-1.
- win_in1..4 hold their last values until the next window; they are meaningful only while win_valid=1.
- Line buffer contents are not reset. Every entry is always written on an even row before it is read on the following odd row.

## Timing
- Reset values: win_in1..4 = 0, win_valid = 0, frame_done = 0, col = 0, row = 0, holding register = 0.
- Latency: win_valid rises on the edge that accepts the bottom-right pixel, so outputs are visible in the following cycle. That is 1 cycle from pixel accept to output.
- win_valid and frame_done are high for exactly one cycle per event; they are never stretched.
- Minimum spacing between win_valid pulses is 2 accepted pixels.
- Gaps (pix_valid=0): counters, line buffer, holding register and outputs all hold. win_valid drops to 0 after its single pulse.
- Back-to-back frames: the pixel after the frame's last pixel is (row 0, col 0) of the next frame. No idle cycle is required.
- Reset mid-frame: the asynchronous reset takes effect immediately and all outputs return to their reset values. The next accepted pixel is treated as (0,0). Partial windows are discarded and no pulse is emitted for them.

## Test plan
- Basic frame:
  - Stimulus: IMG_W=4, IMG_H=2, continuous valid. Row 0 = 1,2,3,4; row 1 = 5,6,7,8.
  - Window 0: win_in1=15'h0001, win_in2=15'h0003, win_in3=15'h001F, win_in4=15'h003F, win_valid pulse 1 cycle after pixel 6.
  - Window 1: codes for 3,4,7,8, with win_valid and frame_done together 1 cycle after pixel 8.
- Encoding edges: a window of 0,15,15,0 -> win_in1=0, win_in2=15'h7FFF, win_in3=15'h7FFF, win_in4=0.
- Gapped input: same frame as the basic test with 3 idle cycles inserted between every pixel -> identical window values. Exactly 2 win_valid pulses, each 1 cycle wide and one cycle after its last pixel.
- Back-to-back frames: IMG_W=4, IMG_H=4, two frames streamed contiguously -> 8 windows total in raster order. frame_done asserts on windows 4 and 8 only.
- Reset mid-frame: assert rst after 5 pixels of a 4x2 frame -> all outputs 0 at once, with no window emitted. A full frame sent afterwards produces the correct 2 windows.
